fifo_sync: RTL and testbench

//  Single-clock first-in/first-out buffer. Stores DEPTH words of DATA_W bits.

---
 rtl/fifo_sync_pkg.sv | 26 ++
 rtl/fifo_sync_mem.sv | 56 +++++
 rtl/fifo_sync.sv | 102 ++++++++++
 tb/tb_fifo_sync.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg
//   Shared definitions for the single-clock FIFO slice.
//   - Default geometry (data width, depth, pointer width) for fifo_sync and
//     its storage sub-module.
//   - An enum naming the four possible per-cycle operations, with a helper
//     that folds the accepted write/read strobes into that enum.
package fifo_sync_pkg;

  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_ADDR_W = 4;

  // Bit 1 = read accepted, bit 0 = write accepted, so the encoding can be
  // built directly from the two strobes.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifoOp_e;

  function automatic fifoOp_e decodeOp(input logic wrOk, input logic rdOk);
    return fifoOp_e'({rdOk, wrOk});
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem
//   DEPTH x DATA_W register array used as FIFO storage.
//   - One synchronous write port.
//   - One registered read port with enable; the read register holds its
//     value while rd_en is low and clears only on reset. The array itself
//     is never cleared.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; loads rd_data from rd_addr
//   rd_addr  in   read address
//   rd_data  out  registered read data
module fifo_sync_mem
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  // Storage has no reset: stale words become unreachable once the
  // pointers are cleared, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // The read register samples the array before any same-edge write lands,
  // so a simultaneous write to the read address never bypasses through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
    end else if (rd_en) begin
      r_rdData <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rdData;

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync
//   Single-clock first-in/first-out buffer of DEPTH words of DATA_W bits.
//   Read data is registered and accompanied by a one-cycle valid strobe.
//   empty/full are decoded combinationally from the registered count.
// Ports
//   clk    in   clock, all state updates on rising edge
//   rst    in   asynchronous active-high reset
//   wr_en  in   write request; din captured when accepted (not full)
//   din    in   write data
//   rd_en  in   read request; accepted when not empty
//   valid  out  high for one cycle when dout holds newly read data
//   dout   out  read data register; holds when no read is accepted
//   empty  out  FIFO holds 0 words
//   full   out  FIFO holds DEPTH words
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;

  logic              w_wrOk;
  logic              w_rdOk;
  fifoOp_e           w_op;

  // Both requests are judged against the flags as they stand before the
  // edge: a full FIFO refuses a write even when a read frees a slot in the
  // same cycle, and an empty FIFO refuses a read even when a word arrives.
  assign empty  = (r_count == '0);
  assign full   = (r_count == FULL_COUNT);
  assign w_wrOk = wr_en & ~full;
  assign w_rdOk = rd_en & ~empty;
  assign w_op   = decodeOp(w_wrOk, w_rdOk);

  // Pointers wrap naturally at DEPTH because they are exactly ADDR_W bits
  // wide; the count carries one extra bit so that DEPTH is representable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case (w_op)
        OP_WRITE: r_count <= r_count + 1'b1;
        OP_READ:  r_count <= r_count - 1'b1;
        default:  r_count <= r_count;
      endcase
    end
  end

  // valid mirrors whether the previous edge accepted a read, which is
  // exactly when the storage read register was reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rdOk;
    end
  end

  assign valid = r_valid;

  fifo_sync_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wrOk),
    .wr_addr (r_wrPtr),
    .wr_data (din),
    .rd_en   (w_rdOk),
    .rd_addr (r_rdPtr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync
//   Directed testbench for fifo_sync (DATA_W=8, DEPTH=16).
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic       valid;
  logic [7:0] dout;
  logic       empty;
  logic       full;

  int checks;
  int failures;

  // Reference occupancy and output state, updated once per clock step.
  logic [7:0] mQ[$];
  logic [7:0] mDout;
  logic       mValid;

  fifo_sync #(
    .DATA_W (8),
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (rd_en),
    .valid (valid),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of requests, advance the reference state using the
  // pre-edge occupancy, then wait until the next falling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d);
    logic wrOk;
    logic rdOk;
    wr_en = wr;
    rd_en = rd;
    din   = d;
    wrOk  = wr && (mQ.size() < 16);
    rdOk  = rd && (mQ.size() != 0);
    if (rdOk) begin
      mDout = mQ.pop_front();
    end
    mValid = rdOk;
    if (wrOk) begin
      mQ.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid), 32'(mValid));
    checkOutput({tag, ".dout"},  32'(dout),  32'(mDout));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(mQ.size() == 0));
    checkOutput({tag, ".full"},  32'(full),  32'(mQ.size() == 16));
  endtask

  task automatic modelReset();
    mQ.delete();
    mDout  = 8'h00;
    mValid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    modelReset();

    // Power-on reset.
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("por.empty", 32'(empty), 32'd1);
    checkOutput("por.full",  32'(full),  32'd0);
    checkOutput("por.valid", 32'(valid), 32'd0);
    checkOutput("por.dout",  32'(dout),  32'd0);
    rst = 1'b0;

    // 1: six writes, one read, then asynchronous reset with 5 words held.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'hA1 + i));
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pre_rst.valid", 32'(valid), 32'd1);
    checkOutput("pre_rst.dout",  32'(dout),  32'hA1);
    checkOutput("pre_rst.empty", 32'(empty), 32'd0);
    rd_en = 1'b0;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst.empty", 32'(empty), 32'd1);
    checkOutput("async_rst.full",  32'(full),  32'd0);
    checkOutput("async_rst.valid", 32'(valid), 32'd0);
    checkOutput("async_rst.dout",  32'(dout),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: fill with 0..15 repeating for 200 cycles; writes past 16 dropped.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i % 16));
      checkOutput($sformatf("fill%0d.full", i),  32'(full),  32'(i >= 15));
      checkOutput($sformatf("fill%0d.empty", i), 32'(empty), 32'd0);
    end

    // 3: drain for 200 cycles; 0..15 back in order, then idle with dout=15.
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("drain%0d.valid", k), 32'(valid), 32'(k < 16));
      checkOutput($sformatf("drain%0d.dout", k),  32'(dout),  (k < 16) ? 32'(k) : 32'd15);
      checkOutput($sformatf("drain%0d.empty", k), 32'(empty), 32'(k >= 15));
      checkOutput($sformatf("drain%0d.full", k),  32'(full),  32'd0);
    end

    // 4: refill to full, then stream with wr_en held and reads alternating.
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h40 + j));
    end
    checkOutput("refill.full", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'hC0);
    checkOutput("stream0.full",  32'(full),  32'd0);
    checkOutput("stream0.dout",  32'(dout),  32'h40);
    checkOutput("stream0.valid", 32'(valid), 32'd1);
    for (int j = 1; j < 40; j++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'hC0 + j));
      checkAll($sformatf("streamBoth%0d", j));
    end
    for (int j = 0; j < 30; j++) begin
      applyStimulus(1'b1, (j % 2) == 1, 8'(8'h10 + j));
      checkAll($sformatf("streamAlt%0d", j));
    end

    // Drain everything and confirm the tail of the stream.
    for (int j = 0; j < 18; j++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkAll($sformatf("streamDrain%0d", j));
    end

    // 5: from empty, simultaneous write and read: only the write lands.
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("emptyCorner.valid", 32'(valid), 32'd0);
    checkOutput("emptyCorner.empty", 32'(empty), 32'd0);
    checkOutput("emptyCorner.full",  32'(full),  32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("emptyCornerRd.valid", 32'(valid), 32'd1);
    checkOutput("emptyCornerRd.dout",  32'(dout),  32'h77);
    checkOutput("emptyCornerRd.empty", 32'(empty), 32'd1);

    // 6: full corner, a dropped write must not disturb stored words.
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h80 + j));
    end
    applyStimulus(1'b1, 1'b0, 8'hEE);
    checkOutput("fullCorner.full",  32'(full),  32'd1);
    checkOutput("fullCorner.valid", 32'(valid), 32'd0);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("fullCornerRd%0d.dout", j),  32'(dout),  32'(8'h80 + j));
      checkOutput($sformatf("fullCornerRd%0d.valid", j), 32'(valid), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("final.valid", 32'(valid), 32'd0);
    checkOutput("final.empty", 32'(empty), 32'd1);
    checkOutput("final.dout",  32'(dout),  32'h8F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
